// File: rtl/input_sequencer.sv
// Push-button front end: two-flop synchroniser, counter debouncer, rising-edge press detect,
// and an A -> B -> F -> SHOW load sequencer driving the downstream select decoder.
module input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,  // must be >= 2
  parameter int CNT_W           = 20        // 2**CNT_W must exceed DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic [1:0] sel,
  output logic       en,
  output logic [1:0] stage
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_F    = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_next;
  logic             s1, s2;
  logic             deb, deb_q;
  logic [CNT_W-1:0] cnt;
  logic             press;

  // NOTE: every clocked register below uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Level only changes after DEBOUNCE_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      deb_q <= deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = deb & ~deb_q;

  // NOTE: state_next gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_next = state;
    if (press) begin
      case (state)
        S_A:     state_next = S_B;
        S_B:     state_next = S_F;
        S_F:     state_next = S_SHOW;
        default: state_next = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_A;
      sel   <= 2'b00;
      en    <= 1'b0;
    end else begin
      state <= state_next;
      en    <= press;
      if (press) sel <= state;
    end
  end

  assign stage = state;

endmodule
